// File: rtl/ysyx_pkg.sv
// Shared types and defaults for the ysyx reorder buffer / commit stage.
package ysyx_pkg;

  localparam int XLEN     = 32;
  localparam int ROB_SIZE = 8;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pnpc;
    logic [XLEN-1:0] npc;
    logic [31:0]     inst;
    logic            sys;
    logic            fence_i;
    logic            fence_time;
    logic            ebreak;
    logic            jen;
    logic            ben;
  } rob_entry_t;

endpackage

// File: rtl/ysyx_rob_commit_if.sv
// Dispatch, completion and commit signals between the pipeline and the ROB.
// The slave modport is the ROB side; master is the pipeline/bench side.
interface ysyx_rob_commit_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 3
);

  logic             disp_valid;
  logic             disp_ready;
  logic [XLEN-1:0]  disp_pc;
  logic [XLEN-1:0]  disp_pnpc;
  logic [31:0]      disp_inst;
  logic             disp_sys;
  logic             disp_fence_i;
  logic             disp_fence_time;
  logic             disp_ebreak;
  logic [IDX_W-1:0] disp_tag;

  logic             cmp_valid;
  logic [IDX_W-1:0] cmp_tag;
  logic [XLEN-1:0]  cmp_npc;
  logic             cmp_jen;
  logic             cmp_ben;

  logic             commit_valid;
  logic [XLEN-1:0]  commit_pc;
  logic [XLEN-1:0]  commit_npc;
  logic [31:0]      commit_inst;
  logic             commit_sys_retire;
  logic             commit_jen;
  logic             commit_ben;
  logic             commit_fence_time;
  logic             commit_fence_i;
  logic             commit_ebreak;
  logic             commit_flush_pipe;

  modport master (
    output disp_valid, disp_pc, disp_pnpc, disp_inst, disp_sys, disp_fence_i,
           disp_fence_time, disp_ebreak,
    output cmp_valid, cmp_tag, cmp_npc, cmp_jen, cmp_ben,
    input  disp_ready, disp_tag,
    input  commit_valid, commit_pc, commit_npc, commit_inst, commit_sys_retire,
           commit_jen, commit_ben, commit_fence_time, commit_fence_i,
           commit_ebreak, commit_flush_pipe
  );

  modport slave (
    input  disp_valid, disp_pc, disp_pnpc, disp_inst, disp_sys, disp_fence_i,
           disp_fence_time, disp_ebreak,
    input  cmp_valid, cmp_tag, cmp_npc, cmp_jen, cmp_ben,
    output disp_ready, disp_tag,
    output commit_valid, commit_pc, commit_npc, commit_inst, commit_sys_retire,
           commit_jen, commit_ben, commit_fence_time, commit_fence_i,
           commit_ebreak, commit_flush_pipe
  );

endinterface

// File: rtl/ysyx_rob_commit.sv
// In-order reorder buffer and single-retire commit stage feeding the WBU.
// Optional YSYX_ROB_PERF_EN adds commit/flush performance counters.
module ysyx_rob_commit import ysyx_pkg::*; #(
  parameter  int XLEN     = ysyx_pkg::XLEN,
  parameter  int ROB_SIZE = ysyx_pkg::ROB_SIZE,
  localparam int IDX_W    = $clog2(ROB_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset,
  ysyx_rob_commit_if.slave      bus,
  output logic [IDX_W:0]        occupancy
`ifdef YSYX_ROB_PERF_EN
  ,
  output logic [31:0]           perf_commit_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(ROB_SIZE);

  rob_entry_t       rob [ROB_SIZE];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic [IDX_W:0]   count_nxt;
  logic             flush_q;

  rob_entry_t       head_e;
  logic [XLEN-1:0]  head_npc;
  logic [XLEN-1:0]  head_pnpc;
  logic             commit_valid;
  logic             commit_flush;
  logic             do_disp;

  assign head_e    = rob[head];
  assign head_npc  = head_e.npc;
  assign head_pnpc = head_e.pnpc;

  // Reset suppresses retirement in its own cycle, even if the head is done.
  assign commit_valid = !reset && head_e.valid && head_e.done;
  assign commit_flush = commit_valid &&
                        ((head_npc != head_pnpc) || head_e.sys || head_e.fence_i);

  assign bus.disp_ready = (count != FULL) && !flush_q;
  assign bus.disp_tag   = tail;
  assign do_disp        = bus.disp_valid && bus.disp_ready;

  assign bus.commit_valid      = commit_valid;
  assign bus.commit_flush_pipe = commit_flush;
  assign bus.commit_pc         = commit_valid ? head_e.pc   : '0;
  assign bus.commit_npc        = commit_valid ? head_npc    : '0;
  assign bus.commit_inst       = commit_valid ? head_e.inst : '0;
  assign bus.commit_sys_retire = commit_valid && head_e.sys;
  assign bus.commit_jen        = commit_valid && head_e.jen;
  assign bus.commit_ben        = commit_valid && head_e.ben;
  assign bus.commit_fence_time = commit_valid && head_e.fence_time;
  assign bus.commit_fence_i    = commit_valid && head_e.fence_i;
  assign bus.commit_ebreak     = commit_valid && head_e.ebreak;

  assign occupancy = count;

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    count_nxt = count;
    case ({do_disp, commit_valid})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: only valid/done are reset; payload fields are qualified by valid and need no reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      flush_q <= 1'b0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob[i].valid <= 1'b0;
        rob[i].done  <= 1'b0;
      end
    end else begin
      flush_q <= commit_flush;
      if (commit_flush) begin
        // Everything younger than the redirecting head is discarded, incl. this cycle's dispatch.
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          rob[i].valid <= 1'b0;
          rob[i].done  <= 1'b0;
        end
      end else begin
        if (bus.cmp_valid && rob[bus.cmp_tag].valid) begin
          rob[bus.cmp_tag].done <= 1'b1;
          rob[bus.cmp_tag].npc  <= bus.cmp_npc;
          rob[bus.cmp_tag].jen  <= bus.cmp_jen;
          rob[bus.cmp_tag].ben  <= bus.cmp_ben;
        end
        if (commit_valid) begin
          rob[head].valid <= 1'b0;
          head            <= head + 1'b1;
        end
        if (do_disp) begin
          rob[tail] <= '{valid:      1'b1,
                         done:       1'b0,
                         pc:         bus.disp_pc,
                         pnpc:       bus.disp_pnpc,
                         npc:        '0,
                         inst:       bus.disp_inst,
                         sys:        bus.disp_sys,
                         fence_i:    bus.disp_fence_i,
                         fence_time: bus.disp_fence_time,
                         ebreak:     bus.disp_ebreak,
                         jen:        1'b0,
                         ben:        1'b0};
          tail <= tail + 1'b1;
        end
        count <= count_nxt;
      end
    end
  end

`ifdef YSYX_ROB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_commit_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (commit_valid) perf_commit_cnt <= perf_commit_cnt + 32'd1;
      if (commit_flush) perf_flush_cnt  <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
